// File: rtl/fma_operand_dispatch.sv
// fma_operand_dispatch: operand-pair FIFO and issue controller for the
// single-precision FMA. Pairs arrive over valid/ready, are queued in a
// DEPTH-entry FIFO, and are presented one at a time on the tied request lines.
// A watchdog parks the controller in ERROR if the FMA never takes a request.
//
// Optional build macro: FMA_DISPATCH_ZERO_FILTER_EN -- when defined, pairs with
// a +/-0 operand complete the handshake but are discarded (zero_drop_out pulses).
module fma_operand_dispatch #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned TIMEOUT  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid_in,
  input  logic [31:0]              op_a_in,
  input  logic [31:0]              op_b_in,
  output logic                     op_ready_out,
  output logic [31:0]              float_0_out,
  output logic [31:0]              float_1_out,
  output logic                     float_0_req_out,
  output logic                     float_1_req_out,
  input  logic                     fma_busy_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     zero_drop_out,
  output logic                     timeout_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     float_0_q, float_1_q;
  logic [63:0]     mem_q [DEPTH];

  logic push;
  logic store;
  logic pop;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // a push even when a pop happens in the same cycle.
  assign op_ready_out = (count_q != CW'(DEPTH));
  assign push         = op_valid_in & op_ready_out;

`ifdef FMA_DISPATCH_ZERO_FILTER_EN
  logic is_zero_pair;
  logic zero_drop_q;

  // A pair with either operand equal to +/-0 is accepted but not stored.
  assign is_zero_pair  = (op_a_in[30:0] == 31'd0) || (op_b_in[30:0] == 31'd0);
  assign store         = push & ~is_zero_pair;
  assign zero_drop_out = zero_drop_q;

  // One-cycle pulse for every discarded pair.
  always_ff @(posedge clk) begin
    if (rst) zero_drop_q <= 1'b0;
    else     zero_drop_q <= push & is_zero_pair;
  end
`else
  assign store         = push;
  assign zero_drop_out = 1'b0;
`endif

  // Issue FSM next-state logic; pop is asserted when the head pair is loaded.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !fma_busy_in) begin
          pop     = 1'b1;
          hold_d  = '0;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold_q != HW'(HOLD_CYC)) hold_d = hold_q + HW'(1);
        if ((hold_q >= HW'(HOLD_CYC - 1)) && fma_busy_in) begin
          state_d = S_EXEC;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (!fma_busy_in) state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy: simultaneous store and pop leave the count unchanged.
  always_comb begin
    count_d = count_q + CW'(store) - CW'(pop);
  end

  // Control state, pointers, counters and operand output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      timer_q   <= '0;
      float_0_q <= '0;
      float_1_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      if (store) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        float_0_q <= mem_q[rd_ptr_q][63:32];
        float_1_q <= mem_q[rd_ptr_q][31:0];
      end
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count decide which entries are valid, so stale contents are never read.
    if (store) mem_q[wr_ptr_q] <= {op_a_in, op_b_in};
  end

  assign float_0_out     = float_0_q;
  assign float_1_out     = float_1_q;
  assign float_0_req_out = (state_q == S_ISSUE);
  assign float_1_req_out = (state_q == S_ISSUE);
  assign count_out       = count_q;
  assign timeout_out     = (state_q == S_ERROR);

endmodule

// File: tb/tb_fma_operand_dispatch.sv
// Self-checking bench for fma_operand_dispatch. A queue-based model of the
// FIFO predicts occupancy, readiness, issue order and zero drops; an FMA
// responder (manual or randomised) plays the downstream unit.
module tb_fma_operand_dispatch;

  localparam int DEPTH    = 4;
  localparam int HOLD_CYC = 2;
  localparam int TIMEOUT  = 20;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef FMA_DISPATCH_ZERO_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid_in;
  logic [31:0]   op_a_in, op_b_in;
  logic          op_ready_out;
  logic [31:0]   float_0_out, float_1_out;
  logic          float_0_req_out, float_1_req_out;
  logic          fma_busy_in;
  logic [CW-1:0] count_out;
  logic          zero_drop_out;
  logic          timeout_out;

  always #5 clk = ~clk;

  fma_operand_dispatch #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid_in(op_valid_in), .op_a_in(op_a_in), .op_b_in(op_b_in),
    .op_ready_out(op_ready_out), .float_0_out(float_0_out), .float_1_out(float_1_out),
    .float_0_req_out(float_0_req_out), .float_1_req_out(float_1_req_out),
    .fma_busy_in(fma_busy_in), .count_out(count_out), .zero_drop_out(zero_drop_out),
    .timeout_out(timeout_out)
  );

  int          nvec = 0;
  int          nfail = 0;
  int          issued = 0;
  logic [63:0] model_q[$];
  logic        req_prev = 1'b0;
  logic [31:0] last_a = '0, last_b = '0;
  bit          auto_fma = 1'b0;
  int          resp_phase = 0;
  int          resp_cnt = 0;

  function automatic bit is_zero(input logic [31:0] f);
    return f[30:0] == 31'd0;
  endfunction

  // One clock: account the handshake, advance, then check every output #1 later.
  task automatic tick(output bit acc);
    bit          drop_exp;
    bit          was_rst;
    logic [63:0] exp_pair;
    was_rst  = rst;
    acc      = !rst && op_valid_in && (model_q.size() != DEPTH);
    drop_exp = 1'b0;
    if (acc) begin
      if (FILTER_ON && (is_zero(op_a_in) || is_zero(op_b_in))) drop_exp = 1'b1;
      else model_q.push_back({op_a_in, op_b_in});
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      model_q.delete();
      req_prev   = 1'b0;
      resp_phase = 0;
    end
    if (float_0_req_out === 1'b1 && !req_prev) begin
      nvec++;
      if (model_q.size() == 0) begin
        nfail++;
        $display("FAIL issue_unexpected: got %h_%h required no request", float_0_out, float_1_out);
      end else begin
        exp_pair = model_q.pop_front();
        if ({float_0_out, float_1_out} !== exp_pair) begin
          nfail++;
          $display("FAIL issue_order: got %h_%h required %h", float_0_out, float_1_out, exp_pair);
        end
      end
      issued++;
      last_a = float_0_out;
      last_b = float_1_out;
    end else if (float_0_req_out === 1'b1) begin
      nvec++;
      if (float_0_out !== last_a || float_1_out !== last_b) begin
        nfail++;
        $display("FAIL operand_stable: got %h_%h required %h_%h", float_0_out, float_1_out, last_a, last_b);
      end
    end
    nvec++;
    if (float_1_req_out !== float_0_req_out) begin
      nfail++;
      $display("FAIL req_tied: req1 %b required %b", float_1_req_out, float_0_req_out);
    end
    nvec++;
    if (count_out !== CW'(model_q.size())) begin
      nfail++;
      $display("FAIL count: got %0d required %0d", count_out, model_q.size());
    end
    nvec++;
    if (op_ready_out !== (model_q.size() != DEPTH)) begin
      nfail++;
      $display("FAIL ready: got %b required %b", op_ready_out, model_q.size() != DEPTH);
    end
    nvec++;
    if (zero_drop_out !== drop_exp) begin
      nfail++;
      $display("FAIL zero_drop: got %b required %b", zero_drop_out, drop_exp);
    end
    if (auto_fma) begin
      nvec++;
      if (timeout_out !== 1'b0) begin
        nfail++;
        $display("FAIL no_timeout: got %b required 0", timeout_out);
      end
    end
    req_prev = float_0_req_out;
    // FMA responder: busy rises 0..3 cycles after a request, lasts 2..5 cycles.
    if (auto_fma) begin
      if (resp_phase == 0 && float_0_req_out === 1'b1) begin
        resp_cnt   = $urandom_range(0, 3);
        resp_phase = 1;
      end
      if (resp_phase == 1) begin
        if (resp_cnt == 0) begin
          fma_busy_in = 1'b1;
          resp_cnt    = $urandom_range(2, 5);
          resp_phase  = 2;
        end else resp_cnt--;
      end else if (resp_phase == 2) begin
        if (resp_cnt <= 1) begin
          fma_busy_in = 1'b0;
          resp_phase  = 0;
        end else resp_cnt--;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    op_valid_in = 1'b0;
    if (resp_phase == 0) fma_busy_in = 1'b0;
    auto_fma = 1'b1;
    while ((model_q.size() != 0 || float_0_req_out || fma_busy_in || resp_phase != 0) && n < 400) begin
      tick(acc);
      n++;
    end
    repeat (3) tick(acc);
    nvec++;
    if (n >= 400) begin
      nfail++;
      $display("FAIL drain_bound: %0d entries left required 0", model_q.size());
    end
    auto_fma    = 1'b0;
    fma_busy_in = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1; op_valid_in = 1'b0; op_a_in = '0; op_b_in = '0; fma_busy_in = 1'b0;
    tick(acc);
    tick(acc);
    rst = 1'b0;
    tick(acc);
    nvec++;
    if ({float_0_out, float_1_out, float_0_req_out, timeout_out} !== 66'd0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h_%h req %b to %b required all 0",
               float_0_out, float_1_out, float_0_req_out, timeout_out);
    end
  endtask

  task automatic test_single();
    bit acc;
    int req_hi;
    int n;
    op_valid_in = 1'b1; op_a_in = 32'h3f800000; op_b_in = 32'h3f800000;
    tick(acc);
    op_valid_in = 1'b0;
    nvec++;
    if (float_0_req_out !== 1'b0) begin
      nfail++; $display("FAIL no_bypass: req %b required 0", float_0_req_out);
    end
    tick(acc);
    nvec++;
    if (float_0_req_out !== 1'b1) begin
      nfail++; $display("FAIL req_rise: req %b required 1", float_0_req_out);
    end
    req_hi = 1;
    fma_busy_in = 1'b1;
    op_valid_in = 1'b1; op_a_in = 32'h40400000; op_b_in = 32'hc0000000;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      if (acc) op_valid_in = 1'b0;
      if (float_0_req_out === 1'b1) req_hi++;
    end
    nvec++;
    if (req_hi != 2) begin
      nfail++; $display("FAIL req_width: got %0d cycles required 2", req_hi);
    end
    fma_busy_in = 1'b0;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (float_0_req_out !== 1'b1 && n < 10);
    nvec++;
    if (n != 2) begin
      nfail++; $display("FAIL reissue_delay: got %0d cycles after busy fell required 2", n);
    end
    drain();
  endtask

  task automatic test_fill();
    bit acc;
    int idx = 0;
    int n = 0;
    fma_busy_in = 1'b1;
    op_valid_in = 1'b1; op_a_in = 32'h41000000; op_b_in = 32'h42000000;
    for (int c = 0; c < 7; c++) begin
      tick(acc);
      if (acc) begin
        idx++;
        op_a_in = 32'h41000000 + 32'(idx);
        op_b_in = 32'h42000000 + 32'(idx);
      end
    end
    nvec++;
    if (idx != DEPTH || count_out !== CW'(DEPTH) || op_ready_out !== 1'b0) begin
      nfail++;
      $display("FAIL fill: accepted %0d count %0d ready %b required 4 4 0", idx, count_out, op_ready_out);
    end
    fma_busy_in = 1'b0;
    auto_fma = 1'b1;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 60);
    nvec++;
    if (!acc) begin
      nfail++; $display("FAIL fill_fifth: accepted 0 required 1");
    end
    drain();
  endtask

  task automatic test_watchdog();
    bit acc;
    op_valid_in = 1'b1; op_a_in = 32'h3fc00000; op_b_in = 32'hbf800000;
    tick(acc);
    op_valid_in = 1'b0;
    tick(acc);
    nvec++;
    if (float_0_req_out !== 1'b1) begin
      nfail++; $display("FAIL wd_issue: req %b required 1", float_0_req_out);
    end
    for (int i = 1; i < TIMEOUT; i++) begin
      tick(acc);
      nvec++;
      if (timeout_out !== 1'b0 || float_0_req_out !== 1'b1) begin
        nfail++;
        $display("FAIL wd_early: cycle %0d timeout %b req %b required 0 1", i, timeout_out, float_0_req_out);
      end
    end
    tick(acc);
    nvec++;
    if (timeout_out !== 1'b1 || float_0_req_out !== 1'b0) begin
      nfail++;
      $display("FAIL wd_fire: timeout %b req %b required 1 0", timeout_out, float_0_req_out);
    end
    op_valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op_a_in = $urandom; op_b_in = $urandom | 32'h3f800000;
      tick(acc);
      nvec++;
      if (timeout_out !== 1'b1 || float_0_req_out !== 1'b0) begin
        nfail++;
        $display("FAIL wd_sticky: timeout %b req %b required 1 0", timeout_out, float_0_req_out);
      end
    end
    op_valid_in = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    nvec++;
    if (timeout_out !== 1'b0) begin
      nfail++; $display("FAIL wd_clear: timeout %b required 0", timeout_out);
    end
  endtask

  task automatic test_zero_filter();
    bit acc;
    int issued0 = issued;
    auto_fma = 1'b1;
    op_valid_in = 1'b1; op_a_in = 32'h00000000; op_b_in = 32'h3f800000;
    tick(acc);
    op_a_in = 32'h80000000; op_b_in = 32'h40000000;
    tick(acc);
    drain();
    nvec++;
    if ((issued - issued0) != (FILTER_ON ? 0 : 2)) begin
      nfail++;
      $display("FAIL zero_pairs_issued: got %0d required %0d", issued - issued0, FILTER_ON ? 0 : 2);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit acc;
    fma_busy_in = 1'b1;
    op_valid_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      op_a_in = 32'h3e000000 + 32'(i); op_b_in = 32'hbe000000 + 32'(i);
      tick(acc);
    end
    op_valid_in = 1'b0;
    fma_busy_in = 1'b0;
    tick(acc);
    nvec++;
    if (float_0_req_out !== 1'b1 || count_out !== CW'(3)) begin
      nfail++;
      $display("FAIL mid_issue_setup: req %b count %0d required 1 3", float_0_req_out, count_out);
    end
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    nvec++;
    if ({float_0_out, float_1_out, float_0_req_out, timeout_out, zero_drop_out} !== 67'd0 ||
        count_out !== '0) begin
      nfail++;
      $display("FAIL mid_issue_reset: got %h_%h req %b count %0d required all 0",
               float_0_out, float_1_out, float_0_req_out, count_out);
    end
    tick(acc);
    nvec++;
    if (float_0_req_out !== 1'b0) begin
      nfail++; $display("FAIL post_reset_req: req %b required 0", float_0_req_out);
    end
  endtask

  task automatic test_push_pop();
    bit acc;
    fma_busy_in = 1'b1;
    op_valid_in = 1'b1; op_a_in = 32'h3f000001; op_b_in = 32'h3f000002;
    tick(acc);
    op_a_in = 32'h3f000003; op_b_in = 32'h3f000004;
    tick(acc);
    fma_busy_in = 1'b0;
    op_a_in = 32'h3f000005; op_b_in = 32'h3f000006;
    tick(acc);
    op_valid_in = 1'b0;
    nvec++;
    if (count_out !== CW'(2) || {float_0_out, float_1_out} !== 64'h3f000001_3f000002) begin
      nfail++;
      $display("FAIL push_pop: count %0d head %h_%h required 2 3f000001_3f000002",
               count_out, float_0_out, float_1_out);
    end
    drain();
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    auto_fma = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (acc || !op_valid_in) begin
        op_valid_in = ($urandom_range(0, 1) == 1);
        op_a_in = $urandom;
        op_b_in = $urandom;
        if ($urandom_range(0, 7) == 0) op_a_in = {$urandom_range(0, 1) == 1, 31'd0};
        if ($urandom_range(0, 7) == 0) op_b_in = {$urandom_range(0, 1) == 1, 31'd0};
      end
      tick(acc);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; op_valid_in = 1'b0; op_a_in = '0; op_b_in = '0; fma_busy_in = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_watchdog();
    test_zero_filter();
    test_reset_mid_issue();
    test_push_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
